load_store_unit: RTL

- Memory-access stage between the execute stage and data_memory.
- Accepts one load/store request at a time over a valid/ready handshake and checks alignment and range.
- Drives data_memory's mem_read/mem_write/address/write_data ports, captures its registered read_data on the cycle it is valid, and returns a tagged response to writeback.
- Hides data_memory's one-cycle synchronous read latency and its zero-when-not-reading output from the pipeline.

---
 rtl/load_store_unit_if.sv | 53 +++++
 rtl/load_store_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Groups the three channels around the load/store unit:
//   request  : req_valid/req_ready handshake plus we/size/signed/addr/wdata/tag
//   response : resp_valid/resp_ready handshake plus rdata/tag/is_load/fault
//   memory   : mem_read/mem_write/mem_address/mem_write_data out, mem_read_data in
// Modports:
//   slave  - the load/store unit side
//   master - the pipeline / memory side (execute, writeback, data_memory)
interface load_store_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [TAG_W-1:0]  req_tag;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_is_load;
    logic              resp_fault;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_tag,
        output req_ready,
        output resp_valid, resp_rdata, resp_tag, resp_is_load, resp_fault,
        input  resp_ready,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_tag,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_tag, resp_is_load, resp_fault,
        output resp_ready,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-access stage between execute and data_memory. Accepts one request
// at a time, checks alignment and range, drives data_memory, hides its
// one-cycle registered read latency and returns a tagged response.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - load_store_unit_if.slave (request, response and memory channels)
// Build option:
//   LSU_BYTE_ACCESS_EN - when defined, byte loads (signed/unsigned) and byte
//   stores (read-modify-write) are supported; otherwise every byte request
//   faults without touching memory.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// ISSUE | memory strobe high for exactly this cycle
// WAIT  | mem_read_data valid this cycle only; capture it
// MERGE | byte store: merged word written (byte build only)
// RESP  | resp_valid=1, held until resp_ready
module load_store_unit #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_WORDS = 64,
    parameter int TAG_W     = 3
) (
    input logic                 clk,
    input logic                 reset,
    load_store_unit_if.slave    bus
);

`ifdef LSU_BYTE_ACCESS_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        MERGE = 3'd3,
        RESP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd4
    } state_t;
`endif

    // One bit wider than the address so 2*MEM_WORDS never wraps.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(2 * MEM_WORDS);

    state_t state;
    logic   l_we;
    logic   req_fault;
    logic [DATA_W-1:0] load_fmt;

`ifdef LSU_BYTE_ACCESS_EN
    logic       l_size;
    logic       l_signed;
    logic       l_lane;
    logic [7:0] l_wbyte;
    logic [7:0] rd_byte;
    logic [DATA_W-1:0] merge_word;
`endif

    always_comb begin
        req_fault = 1'b0;
        if (!bus.req_size && bus.req_addr[0])
            req_fault = 1'b1;
        if ({1'b0, bus.req_addr} >= ADDR_LIMIT)
            req_fault = 1'b1;
`ifndef LSU_BYTE_ACCESS_EN
        if (bus.req_size)
            req_fault = 1'b1;
`endif
    end

`ifdef LSU_BYTE_ACCESS_EN
    // Lane select and formatting work on the word returned in WAIT; the
    // memory drives zero on any other cycle, so nothing here is reused later.
    always_comb begin
        rd_byte    = l_lane ? bus.mem_read_data[15:8] : bus.mem_read_data[7:0];
        merge_word = bus.mem_read_data;
        if (l_lane)
            merge_word[15:8] = l_wbyte;
        else
            merge_word[7:0] = l_wbyte;
        if (!l_size)
            load_fmt = bus.mem_read_data;
        else if (l_signed)
            load_fmt = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
        else
            load_fmt = {{(DATA_W-8){1'b0}}, rd_byte};
    end
`else
    always_comb begin
        load_fmt = bus.mem_read_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            l_we               <= 1'b0;
            bus.req_ready      <= 1'b1;
            bus.resp_valid     <= 1'b0;
            bus.resp_rdata     <= '0;
            bus.resp_tag       <= '0;
            bus.resp_is_load   <= 1'b0;
            bus.resp_fault     <= 1'b0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
`ifdef LSU_BYTE_ACCESS_EN
            l_size             <= 1'b0;
            l_signed           <= 1'b0;
            l_lane             <= 1'b0;
            l_wbyte            <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        l_we             <= bus.req_we;
`ifdef LSU_BYTE_ACCESS_EN
                        l_size           <= bus.req_size;
                        l_signed         <= bus.req_signed;
                        l_lane           <= bus.req_addr[0];
                        l_wbyte          <= bus.req_wdata[7:0];
`endif
                        // Response fields are set up now; they are only
                        // observed once resp_valid rises.
                        bus.req_ready    <= 1'b0;
                        bus.resp_tag     <= bus.req_tag;
                        bus.resp_is_load <= !bus.req_we;
                        bus.resp_rdata   <= '0;
                        bus.resp_fault   <= req_fault;
                        if (req_fault) begin
                            bus.resp_valid <= 1'b1;
                            state          <= RESP;
                        end else begin
                            bus.mem_address    <= bus.req_addr;
                            bus.mem_write_data <= bus.req_wdata;
                            // Byte stores read first, then write the merged word.
                            bus.mem_read       <= !bus.req_we || bus.req_size;
                            bus.mem_write      <= bus.req_we && !bus.req_size;
                            state              <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    bus.mem_read  <= 1'b0;
                    bus.mem_write <= 1'b0;
`ifdef LSU_BYTE_ACCESS_EN
                    if (l_we && !l_size) begin
`else
                    if (l_we) begin
`endif
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
`ifdef LSU_BYTE_ACCESS_EN
                    if (l_we) begin
                        bus.mem_write_data <= merge_word;
                        bus.mem_write      <= 1'b1;
                        state              <= MERGE;
                    end else begin
                        bus.resp_rdata <= load_fmt;
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end
`else
                    bus.resp_rdata <= load_fmt;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
`endif
                end

`ifdef LSU_BYTE_ACCESS_EN
                MERGE: begin
                    bus.mem_write  <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
`endif

                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end

                default: begin
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    bus.mem_read   <= 1'b0;
                    bus.mem_write  <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule
